// File: rtl/stopwatch_pkg.sv
// Shared types, 7-segment codes and BCD helpers for the two-digit stopwatch.
package stopwatch_pkg;

   typedef enum logic [4:0] {
      StIdle    = 5'b00001,
      StRunning = 5'b00010,
      StPaused  = 5'b00100,
      StIncOne  = 5'b01000,
      StIncTen  = 5'b10000
   } state_t;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Packed-BCD increment, 99 wraps to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val);
      logic [7:0] res;
      if (val[3:0] == 4'd9) begin
         res[3:0] = 4'd0;
         res[7:4] = (val[7:4] == 4'd9) ? 4'd0 : val[7:4] + 4'd1;
      end else begin
         res[3:0] = val[3:0] + 4'd1;
         res[7:4] = val[7:4];
      end
      return res;
   endfunction

   function automatic logic [7:0] bcd_tens_inc(input logic [7:0] val);
      logic [7:0] res;
      res[3:0] = val[3:0];
      res[7:4] = (val[7:4] == 4'd9) ? 4'd0 : val[7:4] + 4'd1;
      return res;
   endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and display outputs of the stopwatch; slave is the stopwatch side.
interface stopwatch_if;
   logic       one_button;
   logic       ten_button;
   logic       pause_button;
   logic       clear_button;
   logic [6:0] seg_0;
   logic [6:0] seg_1;
   logic [7:0] bcd_num;
   logic [4:0] fsm_state;

   modport master (
      output one_button, ten_button, pause_button, clear_button,
      input  seg_0, seg_1, bcd_num, fsm_state
   );

   modport slave (
      input  one_button, ten_button, pause_button, clear_button,
      output seg_0, seg_1, bcd_num, fsm_state
   );
endinterface

// File: rtl/button_debounce.sv
// Raw push-button to single-cycle press pulse: 2-FF synchronizer, stability counter,
// rising-edge detect on the accepted level.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw_i,
   output logic btn_pulse_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            pulse_q, pulse_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter tracks consecutive samples that disagree with the accepted level.
   always_comb begin
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign btn_pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_top.sv
// Two-digit BCD stopwatch: button debounce, tick prescaler, one-hot control FSM, 7-seg decode.
// DISPLAY_ACTIVE_LOW_EN inverts both segment outputs for common-anode displays.
module stopwatch_top #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned TICK_CYCLES     = 10_000_000
) (
   input logic       clk,
   input logic       rst,
   stopwatch_if.slave sw_io
);
   import stopwatch_pkg::*;

   localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(TICK_CYCLES - 1);

   logic            rst_meta_q, rst_sync_q;
   logic            one_pulse, ten_pulse, pause_pulse, clear_pulse;
   state_t          state_q, state_d;
   logic [7:0]      count_q, count_d;
   logic [PreW-1:0] presc_q, presc_d;
   logic [6:0]      seg_0_raw, seg_1_raw;

   // Reset asserts immediately, releases on a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= rst_meta_q;
      end
   end

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
      .clk         (clk),
      .rst         (rst_sync_q),
      .btn_raw_i   (sw_io.one_button),
      .btn_pulse_o (one_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ten (
      .clk         (clk),
      .rst         (rst_sync_q),
      .btn_raw_i   (sw_io.ten_button),
      .btn_pulse_o (ten_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
      .clk         (clk),
      .rst         (rst_sync_q),
      .btn_raw_i   (sw_io.pause_button),
      .btn_pulse_o (pause_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk         (clk),
      .rst         (rst_sync_q),
      .btn_raw_i   (sw_io.clear_button),
      .btn_pulse_o (clear_pulse)
   );

   always_ff @(posedge clk or posedge rst_sync_q) begin
      if (rst_sync_q) begin
         state_q <= StIdle;
         count_q <= '0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
      end
   end

   // Priority clear > pause > ten > one; the else-if chain drops the losers.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      if (clear_pulse) begin
         state_d = StIdle;
         count_d = '0;
         presc_d = '0;
      end else begin
         unique case (state_q)
            StIdle, StPaused: begin
               if (pause_pulse) begin
                  state_d = StRunning;
               end else if (ten_pulse) begin
                  state_d = StIncTen;
               end else if (one_pulse) begin
                  state_d = StIncOne;
               end
            end
            StRunning: begin
               if (pause_pulse) begin
                  state_d = StPaused;
               end else if (presc_q == PreMax) begin
                  presc_d = '0;
                  count_d = bcd_inc(count_q);
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            StIncOne: begin
               count_d = bcd_inc(count_q);
               state_d = StPaused;
            end
            StIncTen: begin
               count_d = bcd_tens_inc(count_q);
               state_d = StPaused;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign seg_0_raw = seg_decode(count_q[3:0]);
   assign seg_1_raw = seg_decode(count_q[7:4]);

`ifdef DISPLAY_ACTIVE_LOW_EN
   assign sw_io.seg_0 = ~seg_0_raw;
   assign sw_io.seg_1 = ~seg_1_raw;
`else
   assign sw_io.seg_0 = seg_0_raw;
   assign sw_io.seg_1 = seg_1_raw;
`endif

   assign sw_io.bcd_num   = count_q;
   assign sw_io.fsm_state = state_q;

endmodule

// File: tb/tb_stopwatch_top.sv
// Self-checking bench for stopwatch_top with a cycle model of the control FSM and count.
module tb_stopwatch_top;

   localparam int unsigned DB  = 4;
   localparam int unsigned TK  = 10;
   localparam int          LAT = 7;   // raw edge to visible state change, in clocks

   localparam logic [4:0] S_IDLE = 5'b00001;
   localparam logic [4:0] S_RUN  = 5'b00010;
   localparam logic [4:0] S_PAU  = 5'b00100;
   localparam logic [4:0] S_ONE  = 5'b01000;
   localparam logic [4:0] S_TEN  = 5'b10000;

   typedef struct packed {
      logic [7:0] bcd;
      logic [4:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [4:0] m_state;
   logic [7:0] m_bcd;
   int         m_presc;
   int         pend [4];
   exp_t       exp_q [$];
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   stopwatch_if sw_if ();

   stopwatch_top #(.DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TK)) dut (
      .clk   (clk),
      .rst   (rst),
      .sw_io (sw_if)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [3:0] d);
      logic [6:0] s;
      s = (d < 4'd10) ? seg_tab[d] : 7'h00;
`ifdef DISPLAY_ACTIVE_LOW_EN
      s = ~s;
`endif
      return s;
   endfunction

   function automatic logic [7:0] m_inc(input logic [7:0] v, input int step);
      int n;
      n = (int'(v[7:4]) * 10 + int'(v[3:0]) + step) % 100;
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic model_reset();
      m_state = S_IDLE;
      m_bcd   = 8'h00;
      m_presc = 0;
      for (int i = 0; i < 4; i++) pend[i] = 0;
   endtask

   // One clock: advance the model at the edge, return at the following negedge.
   task automatic cyc();
      logic p1, p10, pp, pc;
      @(posedge clk);
      p1  = (pend[0] == 1);
      p10 = (pend[1] == 1);
      pp  = (pend[2] == 1);
      pc  = (pend[3] == 1);
      for (int i = 0; i < 4; i++) if (pend[i] > 0) pend[i]--;
      if (pc) begin
         m_state = S_IDLE;
         m_bcd   = 8'h00;
         m_presc = 0;
      end else begin
         case (m_state)
            S_IDLE, S_PAU: begin
               if (pp) m_state = S_RUN;
               else if (p10) m_state = S_TEN;
               else if (p1) m_state = S_ONE;
            end
            S_RUN: begin
               if (pp) m_state = S_PAU;
               else if (m_presc == int'(TK) - 1) begin
                  m_presc = 0;
                  m_bcd   = m_inc(m_bcd, 1);
               end else m_presc++;
            end
            S_ONE: begin
               m_bcd   = m_inc(m_bcd, 1);
               m_state = S_PAU;
            end
            S_TEN: begin
               m_bcd   = {(m_bcd[7:4] == 4'd9) ? 4'd0 : m_bcd[7:4] + 4'd1, m_bcd[3:0]};
               m_state = S_PAU;
            end
            default: m_state = S_IDLE;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] mask);
      sw_if.one_button   = mask[0];
      sw_if.ten_button   = mask[1];
      sw_if.pause_button = mask[2];
      sw_if.clear_button = mask[3];
      for (int i = 0; i < 4; i++) if (mask[i]) pend[i] = LAT;
   endtask

   // mask bits: 0 one, 1 ten, 2 pause, 3 clear
   task automatic press(input logic [3:0] mask, input int hold);
      drive(mask);
      repeat (hold) cyc();
      drive(4'b0000);
      repeat (20) cyc();
   endtask

   task automatic test_reset();
      drive(4'b0000);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (sw_if.fsm_state !== S_IDLE) begin
         errors++; $display("FAIL rst_state got %b want %b", sw_if.fsm_state, S_IDLE);
      end
      if (sw_if.bcd_num !== 8'h00) begin
         errors++; $display("FAIL rst_bcd got %h want 00", sw_if.bcd_num);
      end
      if (sw_if.seg_0 !== exp_seg(4'd0)) begin
         errors++; $display("FAIL rst_seg0 got %h want %h", sw_if.seg_0, exp_seg(4'd0));
      end
      if (sw_if.seg_1 !== exp_seg(4'd0)) begin
         errors++; $display("FAIL rst_seg1 got %h want %h", sw_if.seg_1, exp_seg(4'd0));
      end
      rst = 1'b0;
      model_reset();
      repeat (200) cyc();
      checks += 3;
      if (sw_if.fsm_state !== S_IDLE) begin
         errors++; $display("FAIL idle_state got %b want %b", sw_if.fsm_state, S_IDLE);
      end
      if (sw_if.bcd_num !== 8'h00) begin
         errors++; $display("FAIL idle_bcd got %h want 00", sw_if.bcd_num);
      end
      if (sw_if.seg_0 !== exp_seg(4'd0) || sw_if.seg_1 !== exp_seg(4'd0)) begin
         errors++; $display("FAIL idle_segs got %h/%h", sw_if.seg_1, sw_if.seg_0);
      end
      // A bounce shorter than the debounce window must not start the watch.
      sw_if.pause_button = 1'b1;
      repeat (2) cyc();
      sw_if.pause_button = 1'b0;
      repeat (20) cyc();
      checks++;
      if (sw_if.fsm_state !== S_IDLE) begin
         errors++; $display("FAIL bounce_state got %b want %b", sw_if.fsm_state, S_IDLE);
      end
   endtask

   task automatic test_run();
      press(4'b0100, 20);
      for (int i = 0; i < 220; i++) begin
         cyc();
         if (i % 10 == 9) begin
            checks++;
            if (sw_if.bcd_num !== m_bcd || sw_if.fsm_state !== m_state) begin
               errors++;
               $display("FAIL run cyc %0d got %h/%b want %h/%b", i, sw_if.bcd_num,
                        sw_if.fsm_state, m_bcd, m_state);
            end
         end
      end
      checks++;
      if (sw_if.fsm_state !== S_RUN || sw_if.bcd_num !== 8'h25) begin
         errors++;
         $display("FAIL run_end got %h/%b want 25/%b", sw_if.bcd_num, sw_if.fsm_state, S_RUN);
      end
   endtask

   task automatic test_pause();
      logic [7:0] held;
      press(4'b0100, 20);
      held = m_bcd;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (i % 20 == 19) begin
            checks++;
            if (sw_if.bcd_num !== held || sw_if.fsm_state !== S_PAU) begin
               errors++;
               $display("FAIL pause_hold got %h/%b want %h/%b", sw_if.bcd_num,
                        sw_if.fsm_state, held, S_PAU);
            end
         end
      end
      press(4'b0100, 20);
      repeat (30) cyc();
      checks++;
      if (sw_if.bcd_num !== m_bcd || sw_if.fsm_state !== S_RUN) begin
         errors++;
         $display("FAIL resume got %h/%b want %h/%b", sw_if.bcd_num, sw_if.fsm_state,
                  m_bcd, S_RUN);
      end
   endtask

   task automatic test_set();
      logic [3:0] keys [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      logic [7:0] vals [5] = '{8'h10, 8'h20, 8'h30, 8'h31, 8'h32};
      exp_t e;
      press(4'b1000, 20);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{bcd: vals[i], st: S_PAU});
         press(keys[i], 30);
         e = exp_q.pop_front();
         checks++;
         if (sw_if.bcd_num !== e.bcd || sw_if.fsm_state !== e.st) begin
            errors++;
            $display("FAIL set step %0d got %h/%b want %h/%b", i, sw_if.bcd_num,
                     sw_if.fsm_state, e.bcd, e.st);
         end
      end
      checks += 2;
      if (sw_if.seg_1 !== exp_seg(4'd3)) begin
         errors++; $display("FAIL set_seg1 got %h want %h", sw_if.seg_1, exp_seg(4'd3));
      end
      if (sw_if.seg_0 !== exp_seg(4'd2)) begin
         errors++; $display("FAIL set_seg0 got %h want %h", sw_if.seg_0, exp_seg(4'd2));
      end
   endtask

   task automatic test_wrap();
      bit saw_zero = 1'b0;
      repeat (6) press(4'b0010, 20);
      checks++;
      if (sw_if.bcd_num !== 8'h92) begin
         errors++; $display("FAIL tens_to_9 got %h want 92", sw_if.bcd_num);
      end
      press(4'b0010, 20);
      checks++;
      if (sw_if.bcd_num !== 8'h02) begin
         errors++; $display("FAIL tens_wrap got %h want 02", sw_if.bcd_num);
      end
      repeat (9) press(4'b0010, 20);
      repeat (7) press(4'b0001, 20);
      checks++;
      if (sw_if.bcd_num !== 8'h99 || sw_if.seg_1 !== exp_seg(4'd9)) begin
         errors++; $display("FAIL at_99 got %h seg1 %h", sw_if.bcd_num, sw_if.seg_1);
      end
      drive(4'b0100);
      for (int i = 0; i < 40; i++) begin
         if (i == 20) drive(4'b0000);
         cyc();
         checks++;
         if (sw_if.bcd_num !== m_bcd || sw_if.fsm_state !== m_state) begin
            errors++;
            $display("FAIL wrap cyc %0d got %h/%b want %h/%b", i, sw_if.bcd_num,
                     sw_if.fsm_state, m_bcd, m_state);
         end
         if (m_bcd == 8'h00) saw_zero = 1'b1;
      end
      checks++;
      if (!saw_zero || sw_if.fsm_state !== S_RUN) begin
         errors++; $display("FAIL wrap_99 saw_zero %0d state %b", saw_zero, sw_if.fsm_state);
      end
   endtask

   task automatic test_clear_priority();
      press(4'b1100, 20);
      checks += 2;
      if (sw_if.fsm_state !== S_IDLE || sw_if.bcd_num !== 8'h00) begin
         errors++;
         $display("FAIL clr_pause got %h/%b want 00/%b", sw_if.bcd_num, sw_if.fsm_state, S_IDLE);
      end
      if (sw_if.seg_0 !== exp_seg(4'd0) || sw_if.seg_1 !== exp_seg(4'd0)) begin
         errors++; $display("FAIL clr_segs got %h/%h", sw_if.seg_1, sw_if.seg_0);
      end
   endtask

   task automatic test_reset_mid();
      press(4'b0100, 20);
      repeat (30) cyc();
      checks++;
      if (sw_if.fsm_state !== S_RUN || sw_if.bcd_num !== m_bcd) begin
         errors++;
         $display("FAIL pre_rst got %h/%b want %h/%b", sw_if.bcd_num, sw_if.fsm_state,
                  m_bcd, S_RUN);
      end
      #2 rst = 1'b1;
      #1;
      checks += 2;
      if (sw_if.fsm_state !== S_IDLE || sw_if.bcd_num !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst got %h/%b want 00/%b", sw_if.bcd_num, sw_if.fsm_state, S_IDLE);
      end
      if (sw_if.seg_0 !== exp_seg(4'd0) || sw_if.seg_1 !== exp_seg(4'd0)) begin
         errors++; $display("FAIL mid_rst_segs got %h/%h", sw_if.seg_1, sw_if.seg_0);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (20) cyc();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run();
      test_pause();
      test_set();
      test_wrap();
      test_clear_priority();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
